// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Consumer side of the fabric reset. Waits for FABRIC_RESET_N and a qualified
// PLL lock, then releases the RISC-V subsystem resets in a fixed order:
// memory, then bus, then core. The sequence re-runs on PLL lock loss, a
// software reset request or a watchdog reset request, and the cause of the
// last re-run is recorded.
//
// Ports:
//   clk              in   system clock
//   fabric_reset_n   in   asynchronous active-low reset (deasserted sync to clk)
//   pll_lock         in   asynchronous PLL lock, two-flop synchronized here
//   mem_init_done    in   memory initialisation complete (clk domain)
//   sw_rst_req       in   software reset request, single-cycle pulse
//   wdt_rst_req      in   watchdog reset request, single-cycle pulse
//   mem_reset_n      out  memory reset, active-low
//   bus_reset_n      out  interconnect reset, active-low
//   core_reset_n     out  CPU core reset, active-low
//   seq_done         out  high while in RUN
//   rst_cause        out  cause of last sequence: 00 POR, 01 lock loss,
//                         10 SW, 11 WDT
//   init_timeout_err out  sticky memory-init timeout flag
//   seq_state        out  current FSM state (debug visibility)
//
// Handshake note: there is no valid/ready traffic in this block. The request
// inputs are single-cycle pulses sampled on the rising clock edge; they are
// acted upon only outside ASSERT and are otherwise dropped.
// -----------------------------------------------------------------------------
module reset_sequencer #(
   parameter int HOLD_CYCLES  = 8,
   parameter int STAGE_DELAY  = 4,
   parameter int INIT_TIMEOUT = 64,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       fabric_reset_n,
   input  logic       pll_lock,
   input  logic       mem_init_done,
   input  logic       sw_rst_req,
   input  logic       wdt_rst_req,
   output logic       mem_reset_n,
   output logic       bus_reset_n,
   output logic       core_reset_n,
   output logic       seq_done,
   output logic [1:0] rst_cause,
   output logic       init_timeout_err,
   output logic [2:0] seq_state
);

   // ---------------------------------------------------------------------------
   // Parameter sanity: the counter has to reach the largest terminal count.
   // ---------------------------------------------------------------------------
   localparam int MAX_COUNT = (HOLD_CYCLES > STAGE_DELAY) ?
                              ((HOLD_CYCLES > INIT_TIMEOUT) ? HOLD_CYCLES : INIT_TIMEOUT) :
                              ((STAGE_DELAY > INIT_TIMEOUT) ? STAGE_DELAY : INIT_TIMEOUT);

   generate
      if (CNT_W < $clog2(MAX_COUNT + 1)) begin : g_bad_cnt_w
         $error("reset_sequencer: CNT_W too small for the configured delays");
      end
      if (HOLD_CYCLES < 1 || STAGE_DELAY < 1 || INIT_TIMEOUT < 1) begin : g_bad_delay
         $error("reset_sequencer: all delay parameters must be at least 1");
      end
   endgenerate

   // A state with count N exits on the edge where the sampled counter is N-1.
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_DELAY - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INIT_TIMEOUT - 1);

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_LOCK = 2'b01;
   localparam logic [1:0] CAUSE_SW   = 2'b10;
   localparam logic [1:0] CAUSE_WDT  = 2'b11;

   typedef enum logic [2:0] {
      ST_ASSERT    = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_WAIT_MEM  = 3'd2,
      ST_REL_BUS   = 3'd3,
      ST_RUN       = 3'd4
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] next_cnt;
   logic [1:0]       next_cause;
   logic             next_err;
   logic             reentry;
   logic [1:0]       reentry_cause;

   // ---------------------------------------------------------------------------
   // PLL lock synchronizer. Both flops reset to 0 so the sequencer never sees
   // a stale "locked" value coming out of reset.
   // ---------------------------------------------------------------------------
   logic lock_meta;
   logic lock_sync;

   always_ff @(posedge clk or negedge fabric_reset_n) begin
      if (!fabric_reset_n) begin
         lock_meta <= 1'b0;
         lock_sync <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_sync <= lock_meta;
      end
   end

   // ---------------------------------------------------------------------------
   // Re-entry request decode. ASSERT ignores every request; lock loss is not a
   // re-entry cause inside WAIT_LOCK because that state qualifies lock itself.
   // Priority: watchdog, then lock loss, then software.
   // ---------------------------------------------------------------------------
   always_comb begin
      reentry       = 1'b0;
      reentry_cause = CAUSE_POR;
      if (state != ST_ASSERT) begin
         if (wdt_rst_req) begin
            reentry       = 1'b1;
            reentry_cause = CAUSE_WDT;
         end else if (!lock_sync && (state != ST_WAIT_LOCK)) begin
            reentry       = 1'b1;
            reentry_cause = CAUSE_LOCK;
         end else if (sw_rst_req) begin
            reentry       = 1'b1;
            reentry_cause = CAUSE_SW;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state, counter, cause and error-flag logic.
   // ---------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      next_cnt   = cnt + 1'b1;
      next_cause = rst_cause;
      next_err   = init_timeout_err;

      if (reentry) begin
         // Re-entry wins over any stage transition due on the same edge.
         next_state = ST_ASSERT;
         next_cnt   = '0;
         next_cause = reentry_cause;
      end else begin
         unique case (state)
            ST_ASSERT: begin
               if (cnt == HOLD_LAST) begin
                  next_state = ST_WAIT_LOCK;
                  next_cnt   = '0;
               end
            end

            ST_WAIT_LOCK: begin
               // Only consecutive locked cycles count toward qualification.
               if (!lock_sync) begin
                  next_cnt = '0;
               end else if (cnt == STAGE_LAST) begin
                  next_state = ST_WAIT_MEM;
                  next_cnt   = '0;
               end
            end

            ST_WAIT_MEM: begin
               // Done is checked first so it wins over a coincident timeout.
               if (mem_init_done) begin
                  next_state = ST_REL_BUS;
                  next_cnt   = '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  next_state = ST_ASSERT;
                  next_cnt   = '0;
                  next_err   = 1'b1;
               end
            end

            ST_REL_BUS: begin
               if (cnt == STAGE_LAST) begin
                  next_state = ST_RUN;
                  next_cnt   = '0;
               end
            end

            ST_RUN: begin
               // Nothing times out in RUN; hold the counter still.
               next_cnt = cnt;
            end

            default: begin
               next_state = ST_ASSERT;
               next_cnt   = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // State, counter and status registers.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge fabric_reset_n) begin
      if (!fabric_reset_n) begin
         state            <= ST_ASSERT;
         cnt              <= '0;
         rst_cause        <= CAUSE_POR;
         init_timeout_err <= 1'b0;
      end else begin
         state            <= next_state;
         cnt              <= next_cnt;
         rst_cause        <= next_cause;
         init_timeout_err <= next_err;
      end
   end

   // ---------------------------------------------------------------------------
   // Reset outputs are registered from next_state so each one moves on the
   // same edge as the state transition that releases or asserts it.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge fabric_reset_n) begin
      if (!fabric_reset_n) begin
         mem_reset_n  <= 1'b0;
         bus_reset_n  <= 1'b0;
         core_reset_n <= 1'b0;
         seq_done     <= 1'b0;
      end else begin
         mem_reset_n  <= (next_state == ST_WAIT_MEM) ||
                         (next_state == ST_REL_BUS)  ||
                         (next_state == ST_RUN);
         bus_reset_n  <= (next_state == ST_REL_BUS)  ||
                         (next_state == ST_RUN);
         core_reset_n <= (next_state == ST_RUN);
         seq_done     <= (next_state == ST_RUN);
      end
   end

   assign seq_state = state;

   // ---------------------------------------------------------------------------
   // Release ordering: bus never out of reset while memory is held, core
   // never out of reset while bus is held; seq_done tracks the core release.
   // ---------------------------------------------------------------------------
   a_release_order : assert property (
      @(posedge clk) disable iff (!fabric_reset_n)
         (!bus_reset_n || mem_reset_n) && (!core_reset_n || bus_reset_n)
   );

   a_done_matches_core : assert property (
      @(posedge clk) disable iff (!fabric_reset_n)
         seq_done == core_reset_n
   );

endmodule
